// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state encoding, coil phase constants and pattern helpers
// for stepper_output_stage and its optional hold_pwm sub-module.
package stepper_pkg;

    // FSM state encoding (legacy-compatible constants)
    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_DWELL  = 3'd1;
    localparam logic [2:0] ST_STEADY = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // Wave-drive coil phases, forward order A->B->C->D->A
    localparam logic [3:0] PHASE_A = 4'b0001;
    localparam logic [3:0] PHASE_B = 4'b0010;
    localparam logic [3:0] PHASE_C = 4'b0100;
    localparam logic [3:0] PHASE_D = 4'b1000;

    // Next pattern in the forward direction
    function automatic logic [3:0] rotl4(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    // Next pattern in the reverse direction
    function automatic logic [3:0] rotr4(input logic [3:0] p);
        return {p[0], p[3:1]};
    endfunction

    // True for exactly one energised coil
    function automatic logic is_one_hot(input logic [3:0] p);
        return (p == PHASE_A) || (p == PHASE_B) || (p == PHASE_C) || (p == PHASE_D);
    endfunction

    // Legal requests: all-off or a single coil
    function automatic logic is_legal(input logic [3:0] p);
        return (p == 4'b0000) || is_one_hot(p);
    endfunction

endpackage

// File: rtl/stepper_hold_pwm.sv
// hold_pwm: free-running 4-bit counter compared against HOLD_DUTY (in 1/16ths).
// Only built when HOLD_PWM_EN is defined; the default build has no PWM logic.
`ifdef HOLD_PWM_EN
module hold_pwm #(
    parameter int unsigned HOLD_DUTY = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic pwm_on_o
);

    logic [3:0] cnt_q;

    // Free-running PWM phase counter
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign pwm_on_o = ({1'b0, cnt_q} < 5'(HOLD_DUTY));

endmodule
`endif

// File: rtl/stepper_output_stage.sv
// stepper_output_stage: conditions the wave-drive pattern before GPIO/LEDs.
// Enforces a minimum dwell per step, faults on illegal/skipped patterns,
// tracks signed position and flags an idle HOLD state.
// Optional feature macro: HOLD_PWM_EN (PWM holding current in HOLD).
module stepper_output_stage
    import stepper_pkg::*;
#(
    parameter int unsigned MIN_DWELL_CYCLES = 50_000,
    parameter int unsigned IDLE_CYCLES      = 25_000_000,
    parameter int unsigned HOLD_DUTY        = 4,
    parameter int unsigned POS_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           phase_in,
    input  logic                 clear_fault,
    output logic [3:0]           coil_out,
    output logic [POS_WIDTH-1:0] position,
    output logic                 fault,
    output logic                 holding,
    output logic                 busy
);

    localparam int unsigned DW = (MIN_DWELL_CYCLES > 1) ? $clog2(MIN_DWELL_CYCLES) : 1;
    localparam int unsigned IW = $clog2(IDLE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(MIN_DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);

    if (MIN_DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("MIN_DWELL_CYCLES must be at least 1");
    end
    if (IDLE_CYCLES <= MIN_DWELL_CYCLES) begin : g_bad_idle
        $error("IDLE_CYCLES must exceed MIN_DWELL_CYCLES");
    end
    if (HOLD_DUTY > 16) begin : g_bad_duty
        $error("HOLD_DUTY must be in 0..16");
    end

    logic [2:0]           state_q,     state_d;
    logic [3:0]           committed_q, committed_d;
    logic [POS_WIDTH-1:0] position_q,  position_d;
    logic [DW-1:0]        dwell_q,     dwell_d;
    logic [IW-1:0]        idle_q,      idle_d;
    logic [3:0]           coil_q,      coil_d;
    logic                 busy_q,      busy_d;
    logic                 holding_q,   holding_d;
    logic                 fault_q,     fault_d;
    logic                 run_eval;

`ifdef HOLD_PWM_EN
    logic pwm_on;

    hold_pwm #(
        .HOLD_DUTY (HOLD_DUTY)
    ) u_hold_pwm (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .pwm_on_o (pwm_on)
    );
`endif

    // Next-state logic. Each state first sets its no-event outcome; a
    // pattern change evaluated afterwards overrides it, so a step always
    // wins over the idle timeout and the final dwell count.
    always_comb begin
        state_d     = state_q;
        committed_d = committed_q;
        position_d  = position_q;
        dwell_d     = dwell_q;
        idle_d      = idle_q;
        run_eval    = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (is_one_hot(phase_in)) begin
                    committed_d = phase_in;
                    dwell_d     = '0;
                    idle_d      = '0;
                    state_d     = ST_DWELL;
                end else if (!is_legal(phase_in)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    run_eval = 1'b1;
                    idle_d   = '0;
                    state_d  = ST_STEADY;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_STEADY: begin
                run_eval = 1'b1;
                if (idle_q == IDLE_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            ST_HOLD: begin
                run_eval = 1'b1;
            end
            ST_FAULT: begin
                if (clear_fault && (phase_in == 4'b0000)) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (run_eval && (phase_in != committed_q)) begin
            if (phase_in == rotl4(committed_q)) begin
                committed_d = phase_in;
                position_d  = position_q + POS_WIDTH'(1);
                dwell_d     = '0;
                idle_d      = '0;
                state_d     = ST_DWELL;
            end else if (phase_in == rotr4(committed_q)) begin
                committed_d = phase_in;
                position_d  = position_q - POS_WIDTH'(1);
                dwell_d     = '0;
                idle_d      = '0;
                state_d     = ST_DWELL;
            end else if (phase_in == 4'b0000) begin
                state_d = ST_OFF;
            end else begin
                state_d = ST_FAULT;
            end
        end
    end

    // Output decode of the next state, registered alongside it
    always_comb begin
        busy_d    = (state_d == ST_DWELL);
        holding_d = (state_d == ST_HOLD);
        fault_d   = (state_d == ST_FAULT);
        case (state_d)
            ST_DWELL, ST_STEADY: coil_d = committed_d;
`ifdef HOLD_PWM_EN
            ST_HOLD:             coil_d = pwm_on ? committed_d : 4'b0000;
`else
            ST_HOLD:             coil_d = committed_d;
`endif
            default:             coil_d = 4'b0000;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OFF;
            committed_q <= '0;
            position_q  <= '0;
            dwell_q     <= '0;
            idle_q      <= '0;
            coil_q      <= '0;
            busy_q      <= 1'b0;
            holding_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
            position_q  <= position_d;
            dwell_q     <= dwell_d;
            idle_q      <= idle_d;
            coil_q      <= coil_d;
            busy_q      <= busy_d;
            holding_q   <= holding_d;
            fault_q     <= fault_d;
        end
    end

    assign coil_out = coil_q;
    assign position = position_q;
    assign fault    = fault_q;
    assign holding  = holding_q;
    assign busy     = busy_q;

endmodule
